// File: rtl/fifo_uart_pkg.sv
// fifo_uart_pkg
// Shared definitions for the FIFO-drain UART transmitter:
//   tx_state_t  - transmitter FSM states
//   TXD_IDLE    - line level when no frame is being sent (also the stop level)
//   cnt_width() - counter width helper that never returns zero
package fifo_uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   localparam logic TXD_IDLE = 1'b1;

   // $clog2(1) is 0, which would give a zero-width counter.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer
// Counts rclk cycles within one serial bit and flags the last cycle of the bit.
// Ports:
//   rclk     in  block clock
//   rrst_n   in  asynchronous active-low reset
//   clr      in  hold the count at 0 (used while idle so each frame starts aligned)
//   en       in  advance the count
//   bit_done out high on the final cycle of a bit; the count wraps to 0 on the next edge
module uart_bit_timer
   import fifo_uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic rclk,
   input  logic rrst_n,
   input  logic clr,
   input  logic en,
   output logic bit_done
);

   localparam int unsigned TW = cnt_width(CLKS_PER_BIT);
   localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

   logic [TW-1:0] cnt_q, cnt_d;

   assign bit_done = en && !clr && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + TW'(1);
      end
   end

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
// Drains a first-word-fall-through FIFO read port and sends each word as an
// asynchronous serial frame: start(0), DSIZE data bits LSB first, optional even
// parity, stop(1). Runs entirely in the FIFO read clock domain.
// Ports:
//   rclk    in  block clock (FIFO read clock)
//   rrst_n  in  asynchronous active-low reset
//   enable  in  allows a new frame to start; only looked at while idle
//   rempty  in  FIFO empty flag; rdata valid when low
//   rdata   in  FIFO head word
//   rinc    out one-cycle pop strobe, only from IDLE and only when not empty
//   txd     out serial line, idles high
//   busy    out high whenever a frame is in progress
module fifo_uart_tx
   import fifo_uart_pkg::*;
#(
   parameter int unsigned DSIZE        = 8,
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned PARITY_EN    = 0
) (
   input  logic             rclk,
   input  logic             rrst_n,
   input  logic             enable,
   input  logic             rempty,
   input  logic [DSIZE-1:0] rdata,
   output logic             rinc,
   output logic             txd,
   output logic             busy
);

   localparam int unsigned CW = cnt_width(DSIZE);
   localparam logic [CW-1:0] LAST_BIT = CW'(DSIZE - 1);

   tx_state_t        state_q, state_d;
   logic [DSIZE-1:0] shift_q, shift_d;
   logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
   logic             parity_q, parity_d;
   logic             bit_done;
   logic             pop;

   // Reset is folded in so the pop strobe is forced low the moment reset is
   // asserted, even with a non-empty FIFO and enable high.
   assign pop = rrst_n && (state_q == IDLE) && enable && !rempty;

   uart_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_bit_timer (
      .rclk    (rclk),
      .rrst_n  (rrst_n),
      .clr     (state_q == IDLE),
      .en      (state_q != IDLE),
      .bit_done(bit_done)
   );

   // State register
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:   if (pop) state_d = START;
         START:  if (bit_done) state_d = DATA;
         DATA: begin
            if (bit_done && (bit_cnt_q == LAST_BIT)) begin
               state_d = (PARITY_EN != 0) ? PARITY : STOP;
            end
         end
         PARITY: if (bit_done) state_d = STOP;
         STOP:   if (bit_done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      rinc = pop;
      busy = (state_q != IDLE);
      txd  = TXD_IDLE;
      unique case (state_q)
         IDLE:    txd = TXD_IDLE;
         START:   txd = 1'b0;
         DATA:    txd = shift_q[0];
         PARITY:  txd = parity_q;
         STOP:    txd = TXD_IDLE;
         default: txd = TXD_IDLE;
      endcase
   end

   // Datapath: word capture, shifting and bit counting
   always_comb begin
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      parity_d  = parity_q;
      if (pop) begin
         shift_d   = rdata;
         parity_d  = ^rdata;
         bit_cnt_d = '0;
      end else if ((state_q == DATA) && bit_done) begin
         shift_d   = shift_q >> 1;
         bit_cnt_d = (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + CW'(1);
      end
   end

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         shift_q   <= '0;
         bit_cnt_q <= '0;
         parity_q  <= 1'b0;
      end else begin
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         parity_q  <= parity_d;
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx
// Two transmitters (no parity / even parity), CLKS_PER_BIT=4, DSIZE=8, each fed
// by a small first-word-fall-through FIFO model. Directed steps in one initial block.
module tb_fifo_uart_tx;

   logic       rclk;
   logic       rrst_n;
   logic       enable0, enable1;
   logic       rempty0, rempty1;
   logic [7:0] rdata0, rdata1;
   logic       rinc0, rinc1;
   logic       txd0, txd1;
   logic       busy0, busy1;

   int checks;
   int failures;
   int underflow;

   // FIFO models
   logic [7:0] mem0 [16];
   logic [7:0] mem1 [16];
   logic [3:0] rd0, wr0, rd1, wr1;

   assign rempty0 = (rd0 == wr0);
   assign rempty1 = (rd1 == wr1);
   assign rdata0  = mem0[rd0];
   assign rdata1  = mem1[rd1];

   fifo_uart_tx #(
      .DSIZE(8), .CLKS_PER_BIT(4), .PARITY_EN(0)
   ) dut0 (
      .rclk(rclk), .rrst_n(rrst_n), .enable(enable0), .rempty(rempty0),
      .rdata(rdata0), .rinc(rinc0), .txd(txd0), .busy(busy0)
   );

   fifo_uart_tx #(
      .DSIZE(8), .CLKS_PER_BIT(4), .PARITY_EN(1)
   ) dut1 (
      .rclk(rclk), .rrst_n(rrst_n), .enable(enable1), .rempty(rempty1),
      .rdata(rdata1), .rinc(rinc1), .txd(txd1), .busy(busy1)
   );

   initial rclk = 1'b0;
   always #5 rclk = ~rclk;

   // Pop side of the FIFO models; also watch for pops of an empty FIFO.
   always @(posedge rclk) begin
      if (rinc0) rd0 <= rd0 + 4'd1;
      if (rinc1) rd1 <= rd1 + 4'd1;
      if ((rinc0 && rempty0) || (rinc1 && rempty1)) underflow <= underflow + 1;
   end

   function automatic logic rinc_of(input int s);
      return (s == 1) ? rinc1 : rinc0;
   endfunction
   function automatic logic txd_of(input int s);
      return (s == 1) ? txd1 : txd0;
   endfunction
   function automatic logic busy_of(input int s);
      return (s == 1) ? busy1 : busy0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push0(input logic [7:0] d);
      mem0[wr0] = d;
      wr0 = wr0 + 4'd1;
   endtask
   task automatic push1(input logic [7:0] d);
      mem1[wr1] = d;
      wr1 = wr1 + 4'd1;
   endtask

   // Bounded wait for a pop strobe; an expired bound shows up as a failed check.
   task automatic wait_rinc(input int s, input int max);
      int n = 0;
      while (rinc_of(s) !== 1'b1 && n < max) begin
         @(negedge rclk);
         n++;
      end
      chk("wait_rinc", {31'd0, rinc_of(s)}, 32'd1);
   endtask

   // Called in the pop cycle. Checks every cycle of the frame, then steps into
   // the following idle cycle. drop_at >= 0 clears enable0 at that frame cycle.
   task automatic frame(input int s, input logic [7:0] d, input logic par, input int drop_at);
      logic [10:0] bits;
      int nb;
      nb = (s == 1) ? 11 : 10;
      bits = 11'h7ff;
      bits[0] = 1'b0;
      bits[8:1] = d;
      if (s == 1) bits[9] = par;
      chk("pop_rinc", {31'd0, rinc_of(s)}, 32'd1);
      chk("pop_busy", {31'd0, busy_of(s)}, 32'd0);
      chk("pop_txd", {31'd0, txd_of(s)}, 32'd1);
      for (int b = 0; b < nb; b++) begin
         for (int c = 0; c < 4; c++) begin
            @(negedge rclk);
            if (b * 4 + c == drop_at) enable0 = 1'b0;
            chk("frame_txd", {31'd0, txd_of(s)}, {31'd0, bits[b]});
            chk("frame_busy", {31'd0, busy_of(s)}, 32'd1);
            chk("frame_rinc", {31'd0, rinc_of(s)}, 32'd0);
         end
      end
      @(negedge rclk);
      chk("gap_busy", {31'd0, busy_of(s)}, 32'd0);
      chk("gap_txd", {31'd0, txd_of(s)}, 32'd1);
   endtask

   initial begin
      checks = 0;
      failures = 0;
      underflow = 0;
      rd0 = '0; wr0 = '0; rd1 = '0; wr1 = '0;
      for (int i = 0; i < 16; i++) begin
         mem0[i] = '0;
         mem1[i] = '0;
      end
      enable0 = 1'b0;
      enable1 = 1'b0;
      rrst_n  = 1'b0;

      // Reset state
      repeat (3) @(negedge rclk);
      chk("rst_txd0", {31'd0, txd0}, 32'd1);
      chk("rst_busy0", {31'd0, busy0}, 32'd0);
      chk("rst_rinc0", {31'd0, rinc0}, 32'd0);
      chk("rst_txd1", {31'd0, txd1}, 32'd1);
      chk("rst_busy1", {31'd0, busy1}, 32'd0);
      rrst_n = 1'b1;
      @(negedge rclk);

      // Enable gating: word waiting, enable low for 100 cycles
      push0(8'hA5);
      for (int i = 0; i < 100; i++) begin
         @(negedge rclk);
         chk("gate_rinc", {31'd0, rinc0}, 32'd0);
         chk("gate_txd", {31'd0, txd0}, 32'd1);
      end

      // Single word 0xA5: 0,1,0,1,0,0,1,0,1,1 each held 4 cycles
      enable0 = 1'b1;
      #1;
      wait_rinc(0, 2);
      frame(0, 8'hA5, 1'b0, -1);
      chk("a5_done_rinc", {31'd0, rinc0}, 32'd0);
      chk("a5_done_empty", {31'd0, rempty0}, 32'd1);
      chk("a5_pops", {28'd0, rd0}, 32'd1);

      // Empty FIFO for 200 cycles
      for (int i = 0; i < 200; i++) begin
         @(negedge rclk);
         chk("empty_rinc", {31'd0, rinc0}, 32'd0);
         chk("empty_busy", {31'd0, busy0}, 32'd0);
         chk("empty_txd", {31'd0, txd0}, 32'd1);
      end

      // Burst of three words, one idle cycle between frames
      enable0 = 1'b0;
      push0(8'h01);
      push0(8'h02);
      push0(8'h03);
      @(negedge rclk);
      enable0 = 1'b1;
      #1;
      wait_rinc(0, 2);
      frame(0, 8'h01, 1'b0, -1);
      frame(0, 8'h02, 1'b0, -1);
      frame(0, 8'h03, 1'b0, -1);
      chk("burst_end_rinc", {31'd0, rinc0}, 32'd0);
      chk("burst_pops", {28'd0, rd0}, 32'd4);

      // Parity unit: 0xA5 -> parity 0, 0x07 -> parity 1 (44-cycle frames)
      push1(8'hA5);
      enable1 = 1'b1;
      #1;
      wait_rinc(1, 2);
      frame(1, 8'hA5, 1'b0, -1);
      chk("par_gap_rinc", {31'd0, rinc1}, 32'd0);
      push1(8'h07);
      #1;
      wait_rinc(1, 2);
      frame(1, 8'h07, 1'b1, -1);
      chk("par_pops", {28'd0, rd1}, 32'd2);
      enable1 = 1'b0;

      // Enable dropped mid-frame: frame completes, next word stays in FIFO
      enable0 = 1'b0;
      push0(8'h3C);
      push0(8'h99);
      @(negedge rclk);
      enable0 = 1'b1;
      #1;
      wait_rinc(0, 2);
      frame(0, 8'h3C, 1'b0, 13);
      chk("drop_gap_rinc", {31'd0, rinc0}, 32'd0);
      for (int i = 0; i < 20; i++) begin
         @(negedge rclk);
         chk("drop_idle_rinc", {31'd0, rinc0}, 32'd0);
         chk("drop_idle_txd", {31'd0, txd0}, 32'd1);
      end
      chk("drop_pops", {28'd0, rd0}, 32'd5);

      // Reset during DATA: outputs return to idle at once, 0x99 is discarded
      enable0 = 1'b1;
      #1;
      wait_rinc(0, 2);
      repeat (14) @(negedge rclk);
      chk("pre_rst_busy", {31'd0, busy0}, 32'd1);
      #1;
      rrst_n = 1'b0;
      #1;
      chk("midrst_txd", {31'd0, txd0}, 32'd1);
      chk("midrst_busy", {31'd0, busy0}, 32'd0);
      chk("midrst_rinc", {31'd0, rinc0}, 32'd0);
      push0(8'h42);
      repeat (2) @(negedge rclk);
      chk("inrst_rinc", {31'd0, rinc0}, 32'd0);
      chk("inrst_txd", {31'd0, txd0}, 32'd1);
      rrst_n = 1'b1;
      #1;
      wait_rinc(0, 2);
      frame(0, 8'h42, 1'b0, -1);
      chk("post_rst_pops", {28'd0, rd0}, 32'd7);
      chk("no_underflow", underflow, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
